// File: rtl/audio_tdm_deserializer.sv
// Serial audio capture: deserialises I2S / left-justified TDM frames (MSB first) and
// buffers {channel, sample} words in one interleaved show-ahead FIFO.
module audio_tdm_deserializer #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int CH_WIDTH   = 3,
  parameter int FIFO_DEPTH = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int I2S_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  bit_clk_rising_edge,
  input  logic                  frame_start,
  input  logic                  serial_audio_in_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [CH_WIDTH-1:0]   read_channel,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   words_used,
  output logic                  synced,
  output logic                  overflow,
  output logic                  frame_error,
  output logic [15:0]           dropped_frames,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SYNC = 3'd1;
  localparam logic [2:0] SKIP      = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int CW = ADDR_WIDTH + 2;

  logic [2:0]            state;
  logic [BW-1:0]         bit_cnt;
  logic [CH_WIDTH-1:0]   slot_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  admitted;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [CH_WIDTH-1:0]   wr_ch;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CH_WIDTH-1:0]   mem_ch   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic                  fs_hon;
  logic                  in_frame;
  logic                  frame_begin;
  logic                  shift_bit;
  logic [BW-1:0]         bit_idx;
  logic [CH_WIDTH-1:0]   slot_idx;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  admit_now;
  logic                  frame_ok;
  logic                  last_data_bit;
  logic                  last_slot_bit;
  logic                  last_slot;
  logic                  do_write;
  logic                  do_read;

  assign fsm_state = state;

  // A honoured frame_start restarts the frame from any active state; in LJ mode that
  // same bit is bit 0 of slot 0, so the counters are taken as zero on that cycle.
  assign fs_hon      = bit_clk_rising_edge & frame_start;
  assign in_frame    = (state == SKIP) || (state == SHIFT);
  assign frame_begin = enable && fs_hon && (state != IDLE);
  assign shift_bit   = enable && bit_clk_rising_edge &&
                       ((in_frame && !fs_hon) || (frame_begin && (I2S_MODE == 0)));
  assign bit_idx     = frame_begin ? '0 : bit_cnt;
  assign slot_idx    = frame_begin ? '0 : slot_cnt;
  assign shift_next  = (shift_reg << 1) | DATA_WIDTH'(serial_audio_in_data);

  // Whole-frame reservation: the check covers every slot of the frame up front.
  assign admit_now     = (CW'(count) + CW'(CHANNELS)) <= CW'(FIFO_DEPTH);
  assign frame_ok      = frame_begin ? admit_now : admitted;
  assign last_data_bit = (bit_idx == BW'(DATA_WIDTH - 1));
  assign last_slot_bit = (bit_idx == BW'(SLOT_WIDTH - 1));
  assign last_slot     = (slot_idx == CH_WIDTH'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      slot_cnt       <= '0;
      shift_reg      <= '0;
      admitted       <= 1'b0;
      synced         <= 1'b0;
      overflow       <= 1'b0;
      frame_error    <= 1'b0;
      dropped_frames <= '0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      wr_ch          <= '0;
    end else begin
      wr_en <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        synced <= 1'b0;
      end else begin
        if (state == IDLE) state <= WAIT_SYNC;
        if (frame_begin) begin
          synced   <= 1'b1;
          bit_cnt  <= '0;
          slot_cnt <= '0;
          admitted <= admit_now;
          state    <= (I2S_MODE != 0) ? SKIP : SHIFT;
          if (!admit_now) begin
            overflow <= 1'b1;
            if (dropped_frames != 16'hFFFF) dropped_frames <= dropped_frames + 16'd1;
          end
          if (in_frame) frame_error <= 1'b1;
        end
        if (shift_bit) begin
          shift_reg <= shift_next;
          if (last_data_bit && frame_ok) begin
            wr_en   <= 1'b1;
            wr_data <= shift_next;
            wr_ch   <= slot_idx;
          end
          if (last_slot_bit) begin
            bit_cnt <= '0;
            if (last_slot) begin
              state <= GAP;
            end else begin
              slot_cnt <= slot_idx + CH_WIDTH'(1);
              state    <= SHIFT;
            end
          end else begin
            bit_cnt <= bit_idx + BW'(1);
            state   <= SHIFT;
          end
        end
      end
      if (clear) begin
        admitted       <= 1'b0;
        overflow       <= 1'b0;
        frame_error    <= 1'b0;
        dropped_frames <= '0;
        wr_en          <= 1'b0;
      end
    end
  end

  // Read side: read_data/read_channel always present the head word; read_en pops it
  // in the same cycle and is ignored while fifo_empty is high.
  assign do_write = wr_en && !clear && (count != (ADDR_WIDTH + 1)'(FIFO_DEPTH));
  assign do_read  = read_en && !clear && (count != '0);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_data[wr_ptr] <= wr_data;
      mem_ch[wr_ptr]   <= wr_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_read)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign words_used   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == (ADDR_WIDTH + 1)'(FIFO_DEPTH));
  assign read_data    = fifo_empty ? '0 : mem_data[rd_ptr];
  assign read_channel = fifo_empty ? '0 : mem_ch[rd_ptr];

endmodule

// File: tb/tb_audio_tdm_deserializer.sv
// Bench for audio_tdm_deserializer: stereo I2S instance (depth 8) and 8-channel LJ
// instance, randomized frames checked against a frame-level queue model.
module tb_audio_tdm_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic bit_clk = 1'b0;
  logic frame_start = 1'b0;
  logic serial = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic read_en_a = 1'b0;
  logic read_en_b = 1'b0;

  logic [23:0] read_data_a;
  logic [2:0]  read_channel_a;
  logic        fifo_empty_a, fifo_full_a, synced_a, overflow_a, frame_error_a;
  logic [3:0]  words_used_a;
  logic [15:0] dropped_a;
  logic [2:0]  state_a;

  logic [15:0] read_data_b;
  logic [2:0]  read_channel_b;
  logic        fifo_empty_b, fifo_full_b, synced_b, overflow_b, frame_error_b;
  logic [4:0]  words_used_b;
  logic [15:0] dropped_b;
  logic [2:0]  state_b;

  int total = 0;
  int bad = 0;
  logic [26:0] exp_q[$];
  int m_ovf = 0;
  int m_err = 0;
  int m_drop = 0;
  int frame_data [8];

  always #5 clk = ~clk;

  audio_tdm_deserializer #(
    .DATA_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2), .CH_WIDTH(3),
    .FIFO_DEPTH(8), .ADDR_WIDTH(3), .I2S_MODE(1)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .clear(clear),
    .bit_clk_rising_edge(bit_clk), .frame_start(frame_start),
    .serial_audio_in_data(serial), .read_en(read_en_a),
    .read_data(read_data_a), .read_channel(read_channel_a),
    .fifo_empty(fifo_empty_a), .fifo_full(fifo_full_a), .words_used(words_used_a),
    .synced(synced_a), .overflow(overflow_a), .frame_error(frame_error_a),
    .dropped_frames(dropped_a), .fsm_state(state_a)
  );

  audio_tdm_deserializer #(
    .DATA_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(8), .CH_WIDTH(3),
    .FIFO_DEPTH(16), .ADDR_WIDTH(4), .I2S_MODE(0)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .clear(clear),
    .bit_clk_rising_edge(bit_clk), .frame_start(frame_start),
    .serial_audio_in_data(serial), .read_en(read_en_b),
    .read_data(read_data_b), .read_channel(read_channel_b),
    .fifo_empty(fifo_empty_b), .fifo_full(fifo_full_b), .words_used(words_used_b),
    .synced(synced_b), .overflow(overflow_b), .frame_error(frame_error_b),
    .dropped_frames(dropped_b), .fsm_state(state_b)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One serial bit; the pulse lasts one clk and pulses are spaced 4 clk apart.
  task automatic send_bit(input logic b, input logic fs);
    serial = b;
    frame_start = fs;
    bit_clk = 1'b1;
    tick();
    bit_clk = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  function automatic logic frame_bit(input int dw, input int sw, input int k);
    int slot;
    int pos;
    slot = k / sw;
    pos = k % sw;
    if (pos < dw) return frame_data[slot][dw-1-pos];
    return 1'($urandom);
  endfunction

  // Frame start (a discarded lead bit for I2S) followed by frame bits 0..nbits-1.
  task automatic send_frame_bits(input int dw, input int sw, input int i2s, input int nbits);
    if (i2s != 0) send_bit(1'($urandom), 1'b1);
    for (int k = 0; k < nbits; k++) send_bit(frame_bit(dw, sw, k), (i2s == 0) && (k == 0));
  endtask

  task automatic randomize_frame(input int nch, input int dw);
    for (int c = 0; c < nch; c++) frame_data[c] = int'($urandom_range(0, (1 << dw) - 1));
  endtask

  // Reference: whole frame fits or is dropped; only completed slots are stored.
  task automatic model_frame(input int nch, input int depth, input int nslots);
    if (exp_q.size() + nch <= depth) begin
      for (int s = 0; s < nslots; s++) exp_q.push_back({3'(s), 24'(frame_data[s])});
    end else begin
      m_ovf = 1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic pop_a();
    check("a_not_empty", fifo_empty_a, 0);
    check("a_used", words_used_a, exp_q.size());
    check("a_head", {read_channel_a, read_data_a}, exp_q[0]);
    read_en_a = 1'b1;
    tick();
    read_en_a = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic pop_b();
    check("b_not_empty", fifo_empty_b, 0);
    check("b_used", words_used_b, exp_q.size());
    check("b_head", {read_channel_b, 24'(read_data_b)}, exp_q[0]);
    read_en_b = 1'b1;
    tick();
    read_en_b = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic check_flags_a();
    check("a_words", words_used_a, exp_q.size());
    check("a_overflow", overflow_a, m_ovf);
    check("a_frame_error", frame_error_a, m_err);
    check("a_dropped", dropped_a, m_drop);
    check("a_full", fifo_full_a, exp_q.size() == 8);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    m_ovf = 0;
    m_err = 0;
    m_drop = 0;
    check("clr_words", words_used_a, 0);
    check("clr_empty", fifo_empty_a, 1);
    check("clr_flags", {overflow_a, frame_error_a}, 0);
    check("clr_dropped", dropped_a, 0);
  endtask

  task automatic check_reset_a();
    check("rst_data", read_data_a, 0);
    check("rst_channel", read_channel_a, 0);
    check("rst_empty", fifo_empty_a, 1);
    check("rst_full", fifo_full_a, 0);
    check("rst_words", words_used_a, 0);
    check("rst_synced", synced_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_frame_error", frame_error_a, 0);
    check("rst_dropped", dropped_a, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_reset_a();
    check("rst_b_empty", fifo_empty_b, 1);
    reset = 1'b0;
    en_a = 1'b1;
    tick();
    check("a_unsynced", synced_a, 0);

    // Stereo I2S with known samples, checking write latency at bit 23 of slot 0
    frame_data[0] = 32'hABCDEF;
    frame_data[1] = 32'h123456;
    model_frame(2, 8, 2);
    send_frame_bits(24, 32, 1, 23);
    serial = frame_bit(24, 32, 23);
    bit_clk = 1'b1;
    tick();
    bit_clk = 1'b0;
    check("lat1_empty", fifo_empty_a, 1);
    check("lat1_words", words_used_a, 0);
    tick();
    check("lat2_empty", fifo_empty_a, 0);
    check("lat2_words", words_used_a, 1);
    check("lat2_head", {read_channel_a, read_data_a}, 27'h0ABCDEF);
    tick();
    tick();
    for (int k = 24; k < 64; k++) send_bit(frame_bit(24, 32, k), 1'b0);
    check("stereo_synced", synced_a, 1);
    check("stereo_words", words_used_a, 2);
    pop_a();

    // Simultaneous write and pop keeps the occupancy unchanged
    randomize_frame(2, 24);
    model_frame(2, 8, 2);
    send_frame_bits(24, 32, 1, 23);
    serial = frame_bit(24, 32, 23);
    bit_clk = 1'b1;
    tick();
    bit_clk = 1'b0;
    read_en_a = 1'b1;
    tick();
    read_en_a = 1'b0;
    void'(exp_q.pop_front());
    check("rw_words", words_used_a, 1);
    check("rw_head", {read_channel_a, read_data_a}, exp_q[0]);
    tick();
    tick();
    for (int k = 24; k < 64; k++) send_bit(frame_bit(24, 32, k), 1'b0);
    while (exp_q.size() > 0) pop_a();
    check("rw_drained", fifo_empty_a, 1);

    // Overflow: four frames fill depth 8, fifth dropped, sixth admitted after two pops
    do_clear();
    for (int f = 0; f < 5; f++) begin
      randomize_frame(2, 24);
      model_frame(2, 8, 2);
      send_frame_bits(24, 32, 1, 64);
      if (f == 3) check_flags_a();
    end
    check_flags_a();
    pop_a();
    pop_a();
    randomize_frame(2, 24);
    model_frame(2, 8, 2);
    send_frame_bits(24, 32, 1, 64);
    check_flags_a();
    while (exp_q.size() > 0) pop_a();

    // Early frame_start after slot 0 only
    do_clear();
    randomize_frame(2, 24);
    model_frame(2, 8, 1);
    send_frame_bits(24, 32, 1, 32);
    m_err = 1;
    randomize_frame(2, 24);
    model_frame(2, 8, 2);
    send_frame_bits(24, 32, 1, 64);
    check_flags_a();
    while (exp_q.size() > 0) pop_a();

    // enable dropped mid-slot; resync only at the next frame_start
    do_clear();
    randomize_frame(2, 24);
    send_frame_bits(24, 32, 1, 10);
    en_a = 1'b0;
    tick();
    tick();
    check("en_low_synced", synced_a, 0);
    check("en_low_words", words_used_a, 0);
    en_a = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0);
    check("en_wait_synced", synced_a, 0);
    check("en_wait_words", words_used_a, 0);
    randomize_frame(2, 24);
    model_frame(2, 8, 2);
    send_bit(1'($urandom), 1'b1);
    check("en_resynced", synced_a, 1);
    for (int k = 0; k < 64; k++) send_bit(frame_bit(24, 32, k), 1'b0);
    while (exp_q.size() > 0) pop_a();

    // Reset with stored words and sticky flags set
    do_clear();
    for (int f = 0; f < 2; f++) begin
      randomize_frame(2, 24);
      model_frame(2, 8, 2);
      send_frame_bits(24, 32, 1, 64);
    end
    randomize_frame(2, 24);
    model_frame(2, 8, 1);
    send_frame_bits(24, 32, 1, 32);
    m_err = 1;
    for (int f = 0; f < 2; f++) begin
      randomize_frame(2, 24);
      model_frame(2, 8, 2);
      send_frame_bits(24, 32, 1, 64);
    end
    check_flags_a();
    reset = 1'b1;
    tick();
    check_reset_a();
    reset = 1'b0;
    exp_q.delete();
    m_ovf = 0;
    m_err = 0;
    m_drop = 0;

    // Left-justified, 8 channels of 16/16
    en_a = 1'b0;
    en_b = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 8; c++) frame_data[c] = 32'h1000 + c;
    model_frame(8, 16, 8);
    send_frame_bits(16, 16, 0, 128);
    check("b_synced", synced_b, 1);
    check("b_words", words_used_b, 8);
    while (exp_q.size() > 0) pop_b();
    for (int f = 0; f < 2; f++) begin
      randomize_frame(8, 16);
      model_frame(8, 16, 8);
      send_frame_bits(16, 16, 0, 128);
    end
    check("b_full", fifo_full_b, 1);
    check("b_overflow", overflow_b, 0);
    while (exp_q.size() > 0) pop_b();
    check("b_drained", fifo_empty_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
